// File: rtl/lcd_scan_timing_gen.sv
// Raster timing generator for a parallel RGB LCD: pixel strobe, x/y, de, syncs and strobes.
// Optional `LCD_TIMING_FRAME_CNT_EN` enables the 8-bit frame counter output; otherwise it is tied to 0.
module lcd_scan_timing_gen #(
  parameter int CLK_DIV  = 3,
  parameter int H_ACTIVE = 480,
  parameter int H_FRONT  = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BACK   = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FRONT  = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BACK   = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FPORCH,
    PH_SYNC,
    PH_BPORCH
  } phase_e;

  localparam int              DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  function automatic logic [9:0] phase_len(input phase_e s, input logic vert);
    logic [9:0] len;
    len = '0;
    case (s)
      PH_ACTIVE: len = vert ? 10'(V_ACTIVE) : 10'(H_ACTIVE);
      PH_FPORCH: len = vert ? 10'(V_FRONT)  : 10'(H_FRONT);
      PH_SYNC:   len = vert ? 10'(V_SYNC)   : 10'(H_SYNC);
      PH_BPORCH: len = vert ? 10'(V_BACK)   : 10'(H_BACK);
      default:   len = '0;
    endcase
    return len;
  endfunction

  function automatic phase_e phase_succ(input phase_e s);
    phase_e n;
    case (s)
      PH_ACTIVE: n = PH_FPORCH;
      PH_FPORCH: n = PH_SYNC;
      PH_SYNC:   n = PH_BPORCH;
      default:   n = PH_ACTIVE;
    endcase
    return n;
  endfunction

  // Zero-length blanking phases are skipped so the following phase starts on the same tick.
  function automatic phase_e phase_next(input phase_e s, input logic vert);
    phase_e n;
    n = phase_succ(s);
    for (int i = 0; i < 3; i++) begin
      if (n != PH_ACTIVE && phase_len(n, vert) == 10'd0) n = phase_succ(n);
    end
    return n;
  endfunction

  // Counters hold the position presented on the next tick; outputs latch it on that tick.
  logic [DIV_W-1:0] div_q, div_d;
  phase_e           h_state_q, h_state_d, v_state_q, v_state_d;
  logic [9:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;

  logic       pixel_tick_q, pixel_tick_d;
  logic [8:0] x_q, x_d, y_q, y_d;
  logic       de_q, de_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       line_end_q, line_end_d, frame_end_q, frame_end_d;

  logic   tick, h_last, h_wrap, v_last, v_wrap, in_active;
  phase_e h_phase_nxt, v_phase_nxt;

  assign tick        = (div_q == DIV_MAX);
  assign h_phase_nxt = phase_next(h_state_q, 1'b0);
  assign v_phase_nxt = phase_next(v_state_q, 1'b1);
  assign h_last      = (h_cnt_q == phase_len(h_state_q, 1'b0) - 10'd1);
  assign v_last      = (v_cnt_q == phase_len(v_state_q, 1'b1) - 10'd1);
  assign h_wrap      = h_last && (h_phase_nxt == PH_ACTIVE);
  assign v_wrap      = v_last && (v_phase_nxt == PH_ACTIVE);
  assign in_active   = (h_state_q == PH_ACTIVE) && (v_state_q == PH_ACTIVE);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    h_state_d    = h_state_q;
    h_cnt_d      = h_cnt_q;
    v_state_d    = v_state_q;
    v_cnt_d      = v_cnt_q;
    pixel_tick_d = tick;
    line_end_d   = tick && h_wrap;
    frame_end_d  = tick && h_wrap && v_wrap;
    x_d          = x_q;
    y_d          = y_q;
    de_d         = de_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;

    if (tick) begin
      de_d    = in_active;
      x_d     = in_active ? h_cnt_q[8:0] : '0;
      y_d     = in_active ? v_cnt_q[8:0] : '0;
      hsync_d = (h_state_q != PH_SYNC);
      vsync_d = (v_state_q != PH_SYNC);

      if (h_last) begin
        h_state_d = h_phase_nxt;
        h_cnt_d   = '0;
      end else begin
        h_cnt_d   = h_cnt_q + 10'd1;
      end

      if (h_wrap) begin
        if (v_last) begin
          v_state_d = v_phase_nxt;
          v_cnt_d   = '0;
        end else begin
          v_cnt_d   = v_cnt_q + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      div_q        <= '0;
      h_state_q    <= PH_ACTIVE;
      h_cnt_q      <= '0;
      v_state_q    <= PH_ACTIVE;
      v_cnt_q      <= '0;
      pixel_tick_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      de_q         <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      line_end_q   <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_state_q    <= h_state_d;
      h_cnt_q      <= h_cnt_d;
      v_state_q    <= v_state_d;
      v_cnt_q      <= v_cnt_d;
      pixel_tick_q <= pixel_tick_d;
      x_q          <= x_d;
      y_q          <= y_d;
      de_q         <= de_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      line_end_q   <= line_end_d;
      frame_end_q  <= frame_end_d;
    end
  end

  assign pixel_tick = pixel_tick_q;
  assign x          = x_q;
  assign y          = y_q;
  assign de         = de_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign line_end   = line_end_q;
  assign frame_end  = frame_end_q;

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_cnt_q + {7'd0, frame_end_q};

  always_ff @(posedge clock) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_scan_timing_gen.sv
// Bench for lcd_scan_timing_gen: a default-timing instance and a tiny-timing instance (CLK_DIV=1).
// Frame counter expectations follow LCD_TIMING_FRAME_CNT_EN.
module tb_lcd_scan_timing_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       def_rst, sm_rst;
  logic       def_pt, def_de, def_hs, def_vs, def_le, def_fe;
  logic [8:0] def_x, def_y;
  logic [7:0] def_fc;
  logic       sm_pt, sm_de, sm_hs, sm_vs, sm_le, sm_fe;
  logic [8:0] sm_x, sm_y;
  logic [7:0] sm_fc;

  lcd_scan_timing_gen u_def (
    .clock(clock), .reset(def_rst), .pixel_tick(def_pt), .x(def_x), .y(def_y),
    .de(def_de), .hsync(def_hs), .vsync(def_vs), .line_end(def_le),
    .frame_end(def_fe), .frame_cnt(def_fc)
  );

  lcd_scan_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_sm (
    .clock(clock), .reset(sm_rst), .pixel_tick(sm_pt), .x(sm_x), .y(sm_y),
    .de(sm_de), .hsync(sm_hs), .vsync(sm_vs), .line_end(sm_le),
    .frame_end(sm_fe), .frame_cnt(sm_fc)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         tick;
    logic       de;
    logic [8:0] x;
    logic [8:0] y;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fe;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic next_tick_def(output int clks);
    clks = 0;
    do begin
      step();
      clks++;
    end while (!def_pt && clks < 10);
    if (!def_pt) begin
      checks++;
      errors++;
      $display("FAIL def_tick_timeout: no pixel_tick within %0d clocks", clks);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clks, t, cur;
    int de_cnt, hs_low, hs_first, le_cnt, le_tick, fe_cnt, x_bad, x_max, y_bad, vs_low;
    int pt_low, y_max, fc_nz;
    logic [7:0] fc_exp;

    //                tick de    x      y      hs    vs    le    fe
    vecs[0]  = '{0,  1'b1, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3,  1'b1, 9'd3, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4,  1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{5,  1'b0, 9'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{6,  1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{7,  1'b1, 9'd0, 9'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16, 1'b1, 9'd2, 9'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{21, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{28, 1'b0, 9'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{33, 1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{34, 1'b0, 9'd0, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{35, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{41, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{42, 1'b1, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{45, 1'b1, 9'd3, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    def_rst = 1'b1;
    sm_rst  = 1'b1;
    repeat (3) step();

    // Reset state on both instances
    check("def_reset_outs", {def_pt, def_de, def_x, def_y, def_hs, def_vs, def_le, def_fe},
          {1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    check("def_reset_fc", def_fc, 8'd0);
    check("sm_reset_outs", {sm_pt, sm_de, sm_x, sm_y, sm_hs, sm_vs, sm_le, sm_fe},
          {1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});

    // Default timing: first tick three clocks after release
    def_rst = 1'b0;
    step();
    check("def_pt_clk1", def_pt, 1'b0);
    step();
    check("def_pt_clk2", def_pt, 1'b0);
    step();
    check("def_pt_clk3", def_pt, 1'b1);

    de_cnt = 0; hs_low = 0; hs_first = -1; le_cnt = 0; le_tick = -1; fe_cnt = 0;
    x_bad = 0; x_max = 0; y_bad = 0; vs_low = 0;
    for (t = 0; t < 525; t++) begin
      if (t > 0) begin
        next_tick_def(clks);
        if (t <= 3) check($sformatf("def_tick_period_%0d", t), clks, 3);
      end
      if (t < 3) check($sformatf("def_first_px_%0d", t), {def_de, def_x, def_y}, {1'b1, 9'(t), 9'd0});
      if (def_de) de_cnt++;
      if (!def_de && def_x != 9'd0) x_bad++;
      if (int'(def_x) > x_max) x_max = int'(def_x);
      if (def_y != 9'd0) y_bad++;
      if (!def_vs) vs_low++;
      if (def_fe) fe_cnt++;
      if (!def_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = t;
      end
      if (def_le) begin
        le_cnt++;
        le_tick = t;
      end
      if (t == 524) begin
        step();
        check("def_le_one_clock", {def_pt, def_le}, 2'b00);
      end
    end
    check("def_de_count", de_cnt, 480);
    check("def_hs_low_count", hs_low, 41);
    check("def_hs_first_tick", hs_first, 482);
    check("def_le_count", le_cnt, 1);
    check("def_le_tick", le_tick, 524);
    check("def_fe_count", fe_cnt, 0);
    check("def_x_zero_when_blank", x_bad, 0);
    check("def_x_max", x_max, 479);
    check("def_y_line0", y_bad, 0);
    check("def_vs_high_line0", vs_low, 0);
    next_tick_def(clks);
    check("def_line1_start", {def_de, def_x, def_y, def_hs, def_vs}, {1'b1, 9'd0, 9'd1, 1'b1, 1'b1});

    // Reset in the middle of line 1
    for (int i = 0; i < 600 && !(def_de && def_x == 9'd200); i++) next_tick_def(clks);
    check("def_reach_x200", {def_de, def_x}, {1'b1, 9'd200});
    def_rst = 1'b1;
    step();
    check("def_midline_reset_outs", {def_pt, def_de, def_x, def_y, def_hs, def_vs, def_le, def_fe},
          {1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    def_rst = 1'b0;
    next_tick_def(clks);
    check("def_rst_first_tick_clks", clks, 3);
    check("def_rst_first_tick", {def_de, def_x, def_y, def_hs, def_vs}, {1'b1, 9'd0, 9'd0, 1'b1, 1'b1});

    // Tiny timing, per-clock vectors across a full frame and into the next
    sm_rst = 1'b0;
    cur = -1;
    for (int i = 0; i < 15; i++) begin
      while (cur < vecs[i].tick) begin
        step();
        cur++;
      end
      check($sformatf("sm_vec_t%0d", vecs[i].tick),
            {sm_pt, sm_de, sm_x, sm_y, sm_hs, sm_vs, sm_le, sm_fe},
            {1'b1, vecs[i].de, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].le, vecs[i].fe});
    end

    // Reset mid-frame at (2,1)
    for (int i = 0; i < 100 && !(sm_de && sm_x == 9'd2 && sm_y == 9'd1); i++) step();
    check("sm_reach_x2y1", {sm_de, sm_x, sm_y}, {1'b1, 9'd2, 9'd1});
    sm_rst = 1'b1;
    step();
    check("sm_midframe_reset_outs", {sm_pt, sm_de, sm_x, sm_y, sm_hs, sm_vs, sm_le, sm_fe},
          {1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    sm_rst = 1'b0;
    step();
    check("sm_rst_first_tick", {sm_pt, sm_de, sm_x, sm_y, sm_hs, sm_vs}, {1'b1, 1'b1, 9'd0, 9'd0, 1'b1, 1'b1});

    // Reset during hsync must not stretch the pulse
    for (int i = 0; i < 20 && sm_hs; i++) step();
    check("sm_reach_hsync", sm_hs, 1'b0);
    sm_rst = 1'b1;
    step();
    check("sm_rst_in_sync_hs", sm_hs, 1'b1);
    sm_rst = 1'b0;
    step();
    check("sm_after_sync_rst_t0", {sm_hs, sm_de, sm_x}, {1'b1, 1'b1, 9'd0});
    step();
    check("sm_after_sync_rst_t1", {sm_hs, sm_de, sm_x}, {1'b1, 1'b1, 9'd1});

    // 257 frames: strobe counts and frame counter wrap
    sm_rst = 1'b1;
    step();
    sm_rst = 1'b0;
    step();
    de_cnt = 0; hs_low = 0; le_cnt = 0; fe_cnt = 0; vs_low = 0;
    pt_low = 0; x_max = 0; y_max = 0; fc_nz = 0;
    for (t = 0; t < 257 * 42; t++) begin
      if (t > 0) step();
      if (!sm_pt) pt_low++;
      if (sm_de) de_cnt++;
      if (!sm_hs) hs_low++;
      if (!sm_vs) vs_low++;
      if (sm_le) le_cnt++;
      if (sm_fe) fe_cnt++;
      if (sm_fc != 8'd0) fc_nz++;
      if (int'(sm_x) > x_max) x_max = int'(sm_x);
      if (int'(sm_y) > y_max) y_max = int'(sm_y);
`ifdef LCD_TIMING_FRAME_CNT_EN
      if (t == 42)       check("sm_fc_after_frame1", sm_fc, 8'd1);
      if (t == 256 * 42) check("sm_fc_after_frame256", sm_fc, 8'd0);
`endif
    end
    step();
    check("sm_pt_always_high", pt_low, 0);
    check("sm_de_count", de_cnt, 257 * 12);
    check("sm_hs_low_count", hs_low, 257 * 6);
    check("sm_vs_low_count", vs_low, 257 * 7);
    check("sm_le_count", le_cnt, 257 * 6);
    check("sm_fe_count", fe_cnt, 257);
    check("sm_x_max", x_max, 3);
    check("sm_y_max", y_max, 2);
`ifdef LCD_TIMING_FRAME_CNT_EN
    fc_exp = 8'd1;
`else
    fc_exp = 8'd0;
    check("sm_fc_never_nonzero", fc_nz, 0);
    check("def_fc_zero", def_fc, 8'd0);
`endif
    check("sm_fc_after_257_frames", sm_fc, fc_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
